// File: rtl/barrel_pc_sched_if.sv
// ---------------------------------------------------------------------------
// barrel_pc_sched_if
// Bundles the scheduler's control inputs (stall, thread run mask, redirect
// request) and its fetch-issue outputs.
//   slave  : the scheduler (consumes stall/thread_en/redir_*, drives fetch_*)
//   master : the environment around it (execute/fetch side)
// Signals:
//   stall        fetch backpressure, 1 = hold issue
//   thread_en    per-thread run mask
//   redir_valid  redirect request
//   redir_tid    thread being redirected
//   redir_pc     new PC for redir_tid
//   fetch_valid  fetch_tid/fetch_pc carry a real issue
//   fetch_tid    issuing thread
//   fetch_pc     PC to fetch
//   issue_count  count of valid issues (wraps at 2^32)
// ---------------------------------------------------------------------------
interface barrel_pc_sched_if #(
  parameter int NUM_THREADS   = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int TID_WIDTH     = $clog2(NUM_THREADS)
);
  logic                     stall;
  logic [NUM_THREADS-1:0]   thread_en;
  logic                     redir_valid;
  logic [TID_WIDTH-1:0]     redir_tid;
  logic [ADDRESS_WIDTH-1:0] redir_pc;
  logic                     fetch_valid;
  logic [TID_WIDTH-1:0]     fetch_tid;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [31:0]              issue_count;

  modport master (
    output stall, thread_en, redir_valid, redir_tid, redir_pc,
    input  fetch_valid, fetch_tid, fetch_pc, issue_count
  );

  modport slave (
    input  stall, thread_en, redir_valid, redir_tid, redir_pc,
    output fetch_valid, fetch_tid, fetch_pc, issue_count
  );
endinterface

// File: rtl/barrel_pc_sched.sv
// ---------------------------------------------------------------------------
// barrel_pc_sched
// Thread scheduler and per-thread PC file at the front of the barrel CPU.
// Rotates round-robin over NUM_THREADS hardware threads, issues one {tid, pc}
// per cycle to fetch, advances the issuing thread's PC by 4, and accepts
// branch/jump redirects from execute into the PC file.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (overrides stall and redirect)
//   bus  : barrel_pc_sched_if.slave (stall, thread_en, redir_*, fetch_*,
//          issue_count)
// Build option:
//   BARREL_THREAD_SKIP_EN - when defined, the slot search skips disabled
//   threads (first enabled thread at or after ptr, round-robin); when
//   undefined, slots are strictly fixed and disabled threads make bubbles.
// ---------------------------------------------------------------------------
module barrel_pc_sched #(
  parameter int                       NUM_THREADS      = 4,
  parameter int                       ADDRESS_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0,
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_OFFSET = ADDRESS_WIDTH'(32'h100),
  parameter int                       TID_WIDTH        = $clog2(NUM_THREADS)
) (
  input  logic               clk,
  input  logic               rst,
  barrel_pc_sched_if.slave   bus
);

  logic [TID_WIDTH-1:0]     ptr;
  logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];

  logic                     vld_p1;
  logic [TID_WIDTH-1:0]     tid_p1;
  logic [ADDRESS_WIDTH-1:0] pc_p1;
  logic [31:0]              issue_count;

  logic [TID_WIDTH-1:0]     sel_tid_p0;
  logic                     sel_hit_p0;
  logic                     redir_ok_p0;
  logic                     redir_self_p0;
  logic [ADDRESS_WIDTH-1:0] issue_pc_p0;

  // Modular thread index: base + off, wrapping explicitly so NUM_THREADS
  // need not be a power of two.
  function automatic logic [TID_WIDTH-1:0] wrap_add(
    input logic [TID_WIDTH-1:0] base,
    input int                   off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_THREADS) s = s - NUM_THREADS;
    return s[TID_WIDTH-1:0];
  endfunction

  // ---- stage p0: slot selection and redirect qualification ----
`ifdef BARREL_THREAD_SKIP_EN
  // Iterate from the farthest offset down so the nearest enabled thread
  // (round-robin from ptr) is the one left standing.
  always_comb begin
    sel_tid_p0 = ptr;
    sel_hit_p0 = 1'b0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (bus.thread_en[wrap_add(ptr, i)]) begin
        sel_tid_p0 = wrap_add(ptr, i);
        sel_hit_p0 = 1'b1;
      end
    end
  end
`else
  assign sel_tid_p0 = ptr;
  assign sel_hit_p0 = bus.thread_en[ptr];
`endif

  // Out-of-range thread ids are dropped entirely.
  assign redir_ok_p0   = bus.redir_valid &&
                         ({1'b0, bus.redir_tid} < (TID_WIDTH+1)'(NUM_THREADS));
  // A redirect landing in the thread's own issue slot is forwarded so the
  // fetch already uses the new target.
  assign redir_self_p0 = redir_ok_p0 && (bus.redir_tid == sel_tid_p0);
  assign issue_pc_p0   = redir_self_p0 ? bus.redir_pc : pc[sel_tid_p0];

  // ---- stage p1: registered issue and PC file update ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      vld_p1      <= 1'b0;
      tid_p1      <= '0;
      pc_p1       <= '0;
      issue_count <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_PC_OFFSET;
      end
    end else begin
      // Redirects reach the PC file even while stalled; an issue of the same
      // thread below overrides this with the forwarded target + 4.
      if (redir_ok_p0) pc[bus.redir_tid] <= bus.redir_pc;
      if (!bus.stall) begin
        if (sel_hit_p0) begin
          vld_p1          <= 1'b1;
          tid_p1          <= sel_tid_p0;
          pc_p1           <= issue_pc_p0;
          pc[sel_tid_p0]  <= issue_pc_p0 + ADDRESS_WIDTH'(4);
          issue_count     <= issue_count + 32'd1;
          ptr             <= wrap_add(sel_tid_p0, 1);
        end else begin
          vld_p1 <= 1'b0;
`ifndef BARREL_THREAD_SKIP_EN
          // Fixed-slot bubble: the slot still rotates and is reported.
          tid_p1 <= sel_tid_p0;
          ptr    <= wrap_add(sel_tid_p0, 1);
`endif
        end
      end
    end
  end

  assign bus.fetch_valid = vld_p1;
  assign bus.fetch_tid   = tid_p1;
  assign bus.fetch_pc    = pc_p1;
  assign bus.issue_count = issue_count;

endmodule
